// File: rtl/clk_tick_gen.sv
// Multi-channel clock-enable generator: per-channel one-cycle tick and near-50% square wave.
// Divisor writes are shadowed and become active only at a period wrap or on clr.
module clk_tick_gen #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 27,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {27'd50_000_000, 27'd100_000_000, 27'd1_000_000}
) (
  input  logic              clkIn,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic              clr,
  input  logic              wr,
  input  logic [2:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   sq,
  output logic [N_CH-1:0]   pend
);

  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] act [N_CH];
  logic [CNT_W-1:0] shd [N_CH];
  logic [CNT_W-1:0] eff [N_CH];
  logic [N_CH-1:0]  wrap;
  logic [N_CH-1:0]  hit;
  logic [CNT_W-1:0] wr_div_c;

  // A divisor below 2 would make the square wave and the wrap compare degenerate.
  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  assign wr_div_c = clamp(wr_div);

  always_comb begin
    hit  = '0;
    wrap = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit[c]  = wr && (wr_ch == 3'(c));
      wrap[c] = en[c] && (cnt[c] == act[c] - CNT_W'(1));
      // A write landing in the commit cycle wins over the stored shadow.
      eff[c]  = hit[c] ? wr_div_c : shd[c];
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt[c] <= '0;
        act[c] <= clamp(DIV_INIT[c*CNT_W +: CNT_W]);
        shd[c] <= clamp(DIV_INIT[c*CNT_W +: CNT_W]);
      end
      tick <= '0;
      sq   <= '1;
      pend <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (clr) begin
          cnt[c]  <= '0;
          act[c]  <= eff[c];
          shd[c]  <= eff[c];
          tick[c] <= 1'b0;
          sq[c]   <= 1'b1;
          pend[c] <= 1'b0;
        end else begin
          tick[c] <= wrap[c];
          if (wrap[c]) begin
            cnt[c]  <= '0;
            act[c]  <= eff[c];
            shd[c]  <= eff[c];
            sq[c]   <= 1'b1;
            pend[c] <= 1'b0;
          end else begin
            if (en[c]) begin
              cnt[c] <= cnt[c] + CNT_W'(1);
              sq[c]  <= (cnt[c] + CNT_W'(1)) < (act[c] >> 1);
            end
            if (hit[c]) begin
              shd[c]  <= wr_div_c;
              pend[c] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen with a period/phase reference model checked every cycle.
module tb_clk_tick_gen;

  localparam int N_CH  = 3;
  localparam int CNT_W = 8;
  localparam logic [N_CH*CNT_W-1:0] INIT = {8'd5, 8'd4, 8'd3};

  logic             clkIn;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             clr;
  logic             wr;
  logic [2:0]       wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  sq;
  logic [N_CH-1:0]  pend;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  clk_tick_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_INIT(INIT)) dut (
    .clkIn(clkIn), .rst(rst), .en(en), .clr(clr), .wr(wr), .wr_ch(wr_ch),
    .wr_div(wr_div), .tick(tick), .sq(sq), .pend(pend)
  );

  initial begin
    clkIn = 0;
    forever #5 clkIn = ~clkIn;
  end

  // Reference: phase within the current period, active and next divisor.
  typedef struct packed {
    int ph;
    int da;
    int ds;
    bit pn;
    bit tk;
    bit sq;
  } ms_t;

  ms_t ms [N_CH];

  function automatic int init_div(input int c);
    int d;
    d = (c == 0) ? 3 : (c == 1) ? 4 : 5;
    return d;
  endfunction

  function automatic ms_t reset_state(input int c);
    ms_t s;
    s.ph = 0; s.da = init_div(c); s.ds = init_div(c);
    s.pn = 0; s.tk = 0; s.sq = 1;
    return s;
  endfunction

  function automatic ms_t nxt(input ms_t s, input int c, input bit en_c, input bit clr_i,
                              input bit wr_i, input int wch, input int wdiv);
    ms_t n;
    int nd;
    n  = s;
    nd = (wr_i && wch == c) ? ((wdiv < 2) ? 2 : wdiv) : 0;
    if (clr_i) begin
      if (nd > 0) n.ds = nd;
      n.da = n.ds; n.pn = 0; n.ph = 0; n.tk = 0; n.sq = 1;
    end else begin
      n.tk = 0;
      if (en_c) begin
        n.ph = (s.ph + 1) % s.da;
        if (n.ph == 0) begin
          n.tk = 1;
          if (nd > 0) n.ds = nd;
          n.da = n.ds;
          n.pn = 0;
          nd   = 0;
        end
      end
      if (nd > 0) begin
        n.ds = nd;
        n.pn = 1;
      end
      n.sq = n.ph < (n.da / 2);
    end
    return n;
  endfunction

  always @(posedge clkIn or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) ms[c] <= reset_state(c);
    end else begin
      for (int c = 0; c < N_CH; c++)
        ms[c] <= nxt(ms[c], c, en[c], clr, wr, int'(wr_ch), int'(wr_div));
    end
  end

  task automatic chk(input string name, input logic [N_CH-1:0] got, input logic [N_CH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clkIn) begin
    if (chk_on && !rst) begin
      logic [N_CH-1:0] et, es, ep;
      for (int c = 0; c < N_CH; c++) begin
        et[c] = ms[c].tk;
        es[c] = ms[c].sq;
        ep[c] = ms[c].pn;
      end
      chk("model_tick", tick, et);
      chk("model_sq", sq, es);
      chk("model_pend", pend, ep);
    end
  end

  task automatic wait_ph(input int c, input int v);
    for (int i = 0; i < 20; i++) begin
      if (ms[c].ph == v) return;
      @(negedge clkIn);
    end
    n_tests++; n_fail++;
    $display("FAIL wait_ph: channel %0d never reached phase %0d", c, v);
  endtask

  task automatic write(input int ch, input int d);
    wr = 1; wr_ch = 3'(ch); wr_div = CNT_W'(d);
    @(negedge clkIn);
    wr = 0;
  endtask

  // Called right after reset release with en = 111.
  task automatic base_check(input string tag);
    logic [N_CH-1:0] t_tab [6];
    logic [N_CH-1:0] s_tab [6];
    t_tab = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    s_tab = '{3'b110, 3'b000, 3'b001, 3'b010, 3'b110, 3'b101};
    for (int k = 0; k < 6; k++) begin
      @(negedge clkIn);
      chk({tag, "_tick"}, tick, t_tab[k]);
      chk({tag, "_sq"}, sq, s_tab[k]);
    end
  endtask

  initial begin
    logic [N_CH-1:0] e;
    rst = 1; en = '0; clr = 0; wr = 0; wr_ch = '0; wr_div = '0;
    repeat (2) @(negedge clkIn);
    chk("reset_tick", tick, 3'b000);
    chk("reset_sq", sq, 3'b111);
    chk("reset_pend", pend, 3'b000);
    rst = 0; en = 3'b111; chk_on = 1;
    base_check("base");

    // Shadowed write to ch1 while it reads 1.
    wait_ph(1, 1);
    write(1, 6);
    chk("wr1_pend", pend, 3'b010);
    repeat (2) @(negedge clkIn);
    chk("wr1_wrap_tick", {1'b0, tick[1], 1'b0}, 3'b010);
    chk("wr1_wrap_pend", pend, 3'b000);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clkIn);
      chk("wr1_period6", {2'b00, tick[1]}, {2'b00, i == 6});
    end

    // Write coincident with ch0 wrap, then a clamped write of 0.
    wait_ph(0, 2);
    write(0, 7);
    chk("wr0_wrap_tick", {2'b00, tick[0]}, 3'b001);
    chk("wr0_wrap_pend", {2'b00, pend[0]}, 3'b000);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clkIn);
      chk("wr0_period7", {2'b00, tick[0]}, {2'b00, i == 7});
    end
    write(0, 0);
    chk("clamp_pend", {2'b00, pend[0]}, 3'b001);
    for (int i = 0; i < 20 && !ms[0].tk; i++) @(negedge clkIn);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clkIn);
      chk("clamp_sq", {2'b00, sq[0]}, {2'b00, i[0] == 1'b0});
      chk("clamp_tick", {2'b00, tick[0]}, {2'b00, i[0] == 1'b0});
    end

    // Pause ch2 mid-period.
    wait_ph(2, 2);
    en = 3'b011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkIn);
      chk("pause_tick2", {tick[2], 2'b00}, 3'b000);
    end
    en = 3'b111;
    repeat (12) @(negedge clkIn);

    // Global restart: D = 2, 6, 5.
    clr = 1;
    @(negedge clkIn);
    clr = 0;
    chk("clr_sq", sq, 3'b111);
    chk("clr_tick", tick, 3'b000);
    chk("clr_pend", pend, 3'b000);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clkIn);
      e = {i == 5, i == 6, (i % 2) == 0};
      chk("clr_first_ticks", tick, e);
    end

    // Asynchronous reset with a write pending.
    write(2, 9);
    chk("rst_pre_pend", pend, 3'b100);
    @(posedge clkIn);
    #2 rst = 1;
    #1;
    chk("async_tick", tick, 3'b000);
    chk("async_pend", pend, 3'b000);
    chk("async_sq", sq, 3'b111);
    @(negedge clkIn);
    rst = 0;
    base_check("rerst");

    // Out-of-range channel write.
    write(5, 2);
    chk("oor_pend", pend, 3'b000);
    repeat (20) @(negedge clkIn);

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised multi-channel clock-enable generator that replaces the single fixed-tap divider in the chess-timer datapath. Each channel divides `clkIn` by a runtime-programmable integer and produces a one-cycle tick strobe, plus a near-50 % square wave for display blink and scan logic. Divisor changes are double-buffered and take effect only at a period boundary, so running timers never see a short or long period. It sits between the board oscillator and the timekeeping, debounce and 7-segment blocks.

## Interface
- `N_CH`, 3, number of independent channels (1..8)
- `CNT_W`, 27, width of each divisor and counter
- `DIV_INIT`, {50_000_000, 100_000_000, 1_000_000} packed `N_CH*CNT_W`, reset divisor per channel; ch0 in LSBs (100 MHz clock: ch0 = 10 ms, ch1 = 1 s, ch2 = 0.5 s)
- `clkIn`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  N_CH  per-channel run enable
- `clr`  in  1  synchronous restart of all channels
- `wr`  in  1  divisor write strobe, one cycle
- `wr_ch`  in  3  target channel of the write; ignored when ≥ N_CH
- `wr_div`  in  CNT_W  new divisor
- `tick`  out  N_CH  one-cycle strobe per channel period
- `sq`  out  N_CH  square wave per channel
- `pend`  out  N_CH  a written divisor is waiting to become active

## Operation
- Per channel `c`: counter `cnt_c`, active divisor `act_c`, shadow divisor `shd_c`.
- Reset: `cnt_c = 0`, `act_c = shd_c = DIV_INIT[c]`, `tick = 0`, `sq = all ones`, `pend = 0`.
- Divisor clamp: any value < 2 (0 and 1) is stored as 2. The clamp applies to `wr_div` and `DIV_INIT`.
- Counting: with `en[c] = 1`, `cnt_c` steps 0, 1, …, `act_c-1`, 0, … The step from `act_c-1` to 0 is the *wrap*.
- `tick[c]` is a register: `tick[c] <= en[c] & (cnt_c == act_c-1)`. It is high for exactly one cycle, the cycle in which `cnt_c` reads 0 after a wrap.
- `sq[c]` is a register equal to `(cnt_c < act_c/2)` (floor division), computed from the next counter value.
  - High for floor(D/2) cycles and low for ceil(D/2) cycles.
  - The rising edge of `sq` coincides with `tick`.
- `en[c] = 0`: `cnt_c` and `sq[c]` hold, `tick[c] = 0`. Re-enabling resumes from the held count with no extra tick.
- Write: when `wr = 1` and `wr_ch < N_CH`, `shd[wr_ch] <=` the clamped `wr_div` and `pend[wr_ch] <= 1`. Other channels are unaffected.
- Commit: at a wrap of channel `c`, or on `clr`, `act_c <=` the effective shadow and `pend[c] <= 0`.
  - The effective shadow is the same-cycle write value if `wr` targets `c`; otherwise it is `shd_c`.
  - This means a write coincident with a wrap takes effect for the period that is just starting.
- A disabled channel never wraps, so its write stays pending until it is re-enabled and wraps, or until `clr`.
- `clr` (all channels, regardless of `en`): `cnt = 0`, commit shadows, `tick = 0`, `sq = 1`, `pend = 0`. `clr` has priority over counting and over the wrap condition.
- The divisor width rule: `act_c` is at most 2^CNT_W − 1. There is no overflow path because the counter never exceeds `act_c-1`.

## Timing
- After `rst` is released, the first rising edge with `en[c] = 1` moves `cnt_c` from 0 to 1.
- The first `tick[c]` is high during the D-th cycle after release. Later ticks repeat every D cycles.
- Write to active latency: from 1 cycle (write lands in the wrap cycle) up to D_old cycles. `pend` rises the cycle after `wr`.
- Restart latency: after `clr`, the first tick arrives D_new cycles after the `clr` edge.
- Asserting `rst` mid-period forces all outputs to their reset values immediately, with no clock edge required. Pending writes are discarded.
- Outputs are driven only by flip-flops. No combinational path runs from an input to an output.

## Test plan
- **Reset and base ratio.** Bench uses `DIV_INIT` = {5, 4, 3} and `en = 111`. Ticks recur every 3, 4 and 5 cycles, with the first ticks in cycles 3, 4 and 5. `sq` pattern is ch0 1-0-0, ch1 1-1-0-0, ch2 1-1-0-0-0.
- **Double-buffered write.** Write 6 to ch1 while `cnt1 = 1`. `pend[1]` goes high the next cycle. The current period still lasts 4 cycles, later periods last 6, and `pend[1]` clears at the wrap.
- **Write on wrap cycle and clamp.** Write 7 to ch0 in the exact cycle `cnt0 = 2`: the next ch0 period is 7 cycles. Then write 0: after the next wrap the period is 2 and `sq[0]` toggles each cycle.
- **Enable and clr.** Drop `en[2]` for 10 cycles mid-period: `tick[2]` stays 0 and the count resumes without an extra tick. Pulse `clr`: every channel restarts, `sq = 111`, and all first ticks come D cycles later.
- **Asynchronous reset mid-operation.** With a write pending, assert `rst` between clock edges. `tick`, `pend` and `sq` reach 0, 0 and all ones before the next edge, and the divisors return to `DIV_INIT`.
- **Out-of-range channel.** Write with `wr_ch = 5` and `N_CH = 3`: no shadow, `pend` or period change on any channel.
